// File: rtl/clk_div_strobe.sv
// Integer clock divider: one wrap-around counter drives a registered CLOCK, a per-period CE strobe and CNT.
// Latency: all outputs registered; no backpressure. Optional CLKDIV_GATE_EN adds GATE/GATED_CLOCK.
module clk_div_strobe #(
  parameter  int DIVISOR = 8,
  localparam int CW      = (DIVISOR < 3) ? 1 : $clog2(DIVISOR)
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          EN,
  input  logic          CLR,
`ifdef CLKDIV_GATE_EN
  input  logic          GATE,
  output logic          GATED_CLOCK,
`endif
  output logic          CE,
  output logic          CLOCK,
  output logic [CW-1:0] CNT
);

  if (DIVISOR < 2) begin : g_bad_divisor
    $error("clk_div_strobe: DIVISOR must be at least 2");
  end

  localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);
  localparam logic [CW-1:0] HALF = CW'(DIVISOR / 2);

  logic          wrap;
  logic [CW-1:0] nxt;
  logic          clock_nxt;

  assign wrap      = (CNT == LAST);
  assign nxt       = wrap ? '0 : CNT + CW'(1);
  assign clock_nxt = (nxt >= HALF);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      CNT   <= '0;
      CE    <= 1'b0;
      CLOCK <= 1'b0;
    end else if (CLR) begin
      CNT   <= '0;
      CE    <= 1'b0;
      CLOCK <= 1'b0;
    end else if (EN) begin
      CNT   <= nxt;
      CE    <= wrap;
      CLOCK <= clock_nxt;
    end else begin
      CE    <= 1'b0;
    end
  end

`ifdef CLKDIV_GATE_EN
  // GATE is only looked at on the wrap edge, so the gated waveform never carries a partial period.
  logic gate_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      gate_q      <= 1'b0;
      GATED_CLOCK <= 1'b0;
    end else if (CLR) begin
      gate_q      <= 1'b0;
      GATED_CLOCK <= 1'b0;
    end else if (EN) begin
      if (wrap) begin
        gate_q <= GATE;
      end
      GATED_CLOCK <= clock_nxt & (wrap ? GATE : gate_q);
    end
  end
`else
  // Base build: CLOCK is the only divided waveform.
`endif

endmodule

// File: tb/tb_clk_div_strobe.sv
// Directed bench for clk_div_strobe (DIVISOR=8 and DIVISOR=5 side by side) with a scoreboard model.
module tb_clk_div_strobe;

  logic       clk = 1'b0;
  logic       rst_n, en, clr, gate;
  logic       ce8, clock8, ce5, clock5;
  logic [2:0] cnt8, cnt5;
  logic       gclk8, gclk5;

  always #5 clk = ~clk;

  clk_div_strobe #(.DIVISOR(8)) u_div8 (
    .CLK(clk), .RESET_N(rst_n), .EN(en), .CLR(clr),
`ifdef CLKDIV_GATE_EN
    .GATE(gate), .GATED_CLOCK(gclk8),
`endif
    .CE(ce8), .CLOCK(clock8), .CNT(cnt8)
  );

  clk_div_strobe #(.DIVISOR(5)) u_div5 (
    .CLK(clk), .RESET_N(rst_n), .EN(en), .CLR(clr),
`ifdef CLKDIV_GATE_EN
    .GATE(gate), .GATED_CLOCK(gclk5),
`endif
    .CE(ce5), .CLOCK(clock5), .CNT(cnt5)
  );

`ifndef CLKDIV_GATE_EN
  assign gclk8 = 1'b0;
  assign gclk5 = 1'b0;
`endif

  typedef struct {
    int cnt;
    bit ce;
    bit clk;
    bit gq;
    bit gclk;
  } ms_t;

  typedef struct {
    ms_t a;
    ms_t b;
  } exp_t;

  int   checks   = 0;
  int   failures = 0;
  ms_t  m8, m5;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic ms_t model(input int div, input ms_t s, input bit e, input bit c, input bit g);
    ms_t n = s;
    bit  w;
    if (c) begin
      n = '{default: 0};
    end else if (e) begin
      w      = (s.cnt == div - 1);
      n.cnt  = w ? 0 : s.cnt + 1;
      n.ce   = w;
      n.clk  = (n.cnt >= div / 2);
      n.gclk = n.clk & (w ? g : s.gq);
      if (w) n.gq = g;
    end else begin
      n.ce = 1'b0;
    end
    return n;
  endfunction

  task automatic step();
    exp_t e;
    e.a = model(8, m8, en, clr, gate);
    e.b = model(5, m5, en, clr, gate);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("cnt8",   32'(cnt8),   32'(e.a.cnt));
    check("ce8",    32'(ce8),    32'(e.a.ce));
    check("clock8", 32'(clock8), 32'(e.a.clk));
    check("cnt5",   32'(cnt5),   32'(e.b.cnt));
    check("ce5",    32'(ce5),    32'(e.b.ce));
    check("clock5", 32'(clock5), 32'(e.b.clk));
`ifdef CLKDIV_GATE_EN
    check("gclk8",  32'(gclk8),  32'(e.a.gclk));
    check("gclk5",  32'(gclk5),  32'(e.b.gclk));
`endif
    m8 = e.a;
    m5 = e.b;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_cnt8"},   32'(cnt8),   32'd0);
    check({tag, "_ce8"},    32'(ce8),    32'd0);
    check({tag, "_clock8"}, 32'(clock8), 32'd0);
    check({tag, "_cnt5"},   32'(cnt5),   32'd0);
    check({tag, "_ce5"},    32'(ce5),    32'd0);
    check({tag, "_clock5"}, 32'(clock5), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first_rise, first_ce, last_ce, periods, n_ce5, k;

    rst_n = 1'b0;
    en    = 1'b0;
    clr   = 1'b0;
    gate  = 1'b0;
    m8    = '{default: 0};
    m5    = '{default: 0};

    // Reset held: outputs stay clear while CLK toggles.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_zero("reset");
    end

    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;

    // Basic division: 88 enabled edges give 11 CEs on the /8 and 17 on the /5.
    first_rise = -1;
    first_ce   = -1;
    last_ce    = -1;
    periods    = 0;
    n_ce5      = 0;
    for (int i = 1; i <= 88; i++) begin
      step();
      if (clock8 && first_rise < 0) first_rise = i;
      if (ce8) begin
        if (first_ce < 0) first_ce = i;
        else begin
          check("period8", 32'(i - last_ce), 32'd8);
          periods++;
        end
        last_ce = i;
      end
      if (ce5) n_ce5++;
    end
    check("first_rise8", 32'(first_rise), 32'd4);
    check("first_ce8",   32'(first_ce),   32'd8);
    check("periods8",    32'(periods),    32'd10);
    check("ce5_count",   32'(n_ce5),      32'd17);

    // Enable hold at CNT=3 for 6 cycles: next CE lands 6 cycles late (11 instead of 5).
    for (int i = 0; i < 16 && m8.cnt != 3; i++) step();
    check("hold_start_cnt8", 32'(cnt8), 32'd3);
    en = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check("hold_cnt8", 32'(cnt8), 32'd3);
    en = 1'b1;
    k = 6;
    for (int i = 0; i < 20; i++) begin
      step();
      k++;
      if (ce8) break;
    end
    check("hold_ce_delay", 32'(k), 32'd11);

    // CLR at CNT=6 with EN high.
    for (int i = 0; i < 16 && m8.cnt != 6; i++) step();
    check("clr_start_cnt8", 32'(cnt8), 32'd6);
    clr = 1'b1;
    step();
    check_zero("clr");
    clr = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("clr_resume_cnt8", 32'(cnt8), 32'd3);

    // Async reset between edges at CNT=5.
    for (int i = 0; i < 16 && m8.cnt != 5; i++) step();
    check("areset_start_cnt8", 32'(cnt8), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("areset");
    check("areset_gclk8", 32'(gclk8), 32'd0);
    m8 = '{default: 0};
    m5 = '{default: 0};
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check("areset_resume_cnt8", 32'(cnt8), 32'd2);

`ifdef CLKDIV_GATE_EN
    // GATE raised mid-period: gated output waits for the wrap, then follows CLOCK.
    gate = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("gate_wait", 32'(gclk8), 32'd0);
    end
    step();
    check("gate_wrap_cnt8", 32'(cnt8), 32'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      check("gate_follow", 32'(gclk8), 32'(clock8));
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
